// File: rtl/peak_axil_regs_pkg.sv
// Shared constants and helpers for the peak finder AXI4-Lite register file.
// Register indices, response codes and the byte-strobe merge function.
package peak_axil_pkg;

    localparam int NUM_REGS   = 4;
    localparam int REG_CTRL   = 0;
    localparam int REG_THRESH = 1;
    localparam int REG_WINDOW = 2;
    localparam int REG_MODE   = 3;
    localparam int REG_STATUS = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [31:0] reg_word_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic reg_word_t apply_wstrb(reg_word_t old_w, reg_word_t data, logic [3:0] strb);
        reg_word_t res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/peak_axil_regs_if.sv
// AXI4-Lite bus between the master VIP and the peak finder register file.
interface peak_axil_regs_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/peak_axil_regs.sv
// AXI4-Lite register file for the peak finder: four RW control words.
// Optional feature macro PEAK_AXIL_STATUS_EN adds a read-only status word at 0x10.
module peak_axil_regs
    import peak_axil_pkg::*;
#(
    parameter int        C_S_AXI_DATA_WIDTH = 32,
    parameter int        C_S_AXI_ADDR_WIDTH = 5,
    parameter reg_word_t RST_VAL0           = '0,
    parameter reg_word_t RST_VAL1           = '0,
    parameter reg_word_t RST_VAL2           = '0,
    parameter reg_word_t RST_VAL3           = '0
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    peak_axil_regs_if.slave               s_axi,
`ifdef PEAK_AXIL_STATUS_EN
    input  reg_word_t                     peak_status_i,
`endif
    output logic [NUM_REGS-1:0][31:0]     reg_o,
    output logic [NUM_REGS-1:0]           reg_wr_o
);

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_dw
        $error("peak_axil_regs: only 32-bit data is supported");
    end
    if (C_S_AXI_ADDR_WIDTH < 5) begin : g_bad_aw
        $error("peak_axil_regs: address must be at least 5 bits");
    end

    localparam logic [NUM_REGS-1:0][31:0] RST_VALS = {RST_VAL3, RST_VAL2, RST_VAL1, RST_VAL0};

    logic [NUM_REGS-1:0][31:0] r_regs;
    logic [NUM_REGS-1:0]       r_reg_wr;
    logic                      r_aw_full;
    logic [2:0]                r_aw_idx;
    logic                      r_w_full;
    reg_word_t                 r_wdata;
    logic [3:0]                r_wstrb;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic                      r_rvalid;
    logic [1:0]                r_rresp;
    reg_word_t                 r_rdata;

    logic       w_awready, w_wready, w_arready;
    logic       w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [2:0] w_ar_idx;
    reg_word_t  w_rd_data;
    logic [1:0] w_rd_resp;
    logic       w_unused;

    // READY is forced low while reset is asserted so nothing is accepted in that cycle.
    assign w_awready = !S_AXI_ARESET && !r_aw_full && !r_bvalid;
    assign w_wready  = !S_AXI_ARESET && !r_w_full && !r_bvalid;
    assign w_arready = !S_AXI_ARESET && !r_rvalid;
    assign w_aw_hs   = s_axi.S_AXI_AWVALID && w_awready;
    assign w_w_hs    = s_axi.S_AXI_WVALID && w_wready;
    assign w_ar_hs   = s_axi.S_AXI_ARVALID && w_arready;
    assign w_commit  = r_aw_full && r_w_full;
    assign w_ar_idx  = s_axi.S_AXI_ARADDR[4:2];
    assign w_unused  = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // Write path: independent AW/W holding regs, commit when both are full, then hold B.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_regs    <= RST_VALS;
            r_reg_wr  <= '0;
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_w_full  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_reg_wr <= '0;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= s_axi.S_AXI_AWADDR[4:2];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_axi.S_AXI_WDATA;
                r_wstrb  <= s_axi.S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                // Status word (index 4) and 5..7 are not writable.
                if (!r_aw_idx[2]) begin
                    r_regs[r_aw_idx[1:0]]   <= apply_wstrb(r_regs[r_aw_idx[1:0]], r_wdata, r_wstrb);
                    r_reg_wr[r_aw_idx[1:0]] <= 1'b1;
                    r_bresp                 <= RESP_OKAY;
                end else begin
                    r_bresp <= RESP_SLVERR;
                end
            end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read decode against register contents at the handshake cycle.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        if (!w_ar_idx[2]) begin
            w_rd_data = r_regs[w_ar_idx[1:0]];
            w_rd_resp = RESP_OKAY;
        end
`ifdef PEAK_AXIL_STATUS_EN
        else if (w_ar_idx == 3'(REG_STATUS)) begin
            w_rd_data = peak_status_i;
            w_rd_resp = RESP_OKAY;
        end
`endif
    end

    // Read path: capture on AR handshake, hold R until the master takes it.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axi.S_AXI_AWREADY = w_awready;
    assign s_axi.S_AXI_WREADY  = w_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = w_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign reg_o               = r_regs;
    assign reg_wr_o            = r_reg_wr;

endmodule
